// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter slice.
//   state_t   : FSM encoding (IDLE = 0, BUSY = 1)
//   NREQ      : number of requesters (4)
//   DEFAULT_N : default data width (16)
//   rr_pick   : circular first-set-bit search starting at a pointer
//   onehot    : index to one-hot grant vector
package rr_arb_pkg;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned DEFAULT_N = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef logic [1:0] idx_t;

  // First requester with req set, searching ptr, ptr+1, ... modulo NREQ.
  // Result is only meaningful when req is nonzero.
  function automatic idx_t rr_pick(input logic [NREQ-1:0] req, input idx_t ptr);
    idx_t win;
    idx_t cand;
    logic found;
    win   = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = ptr + idx_t'(k);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input idx_t i);
    logic [NREQ-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Bus bundle between four requesters / one consumer and the arbiter.
//   req, d0..d3, out_ready         : driven by the environment (master)
//   out_valid, out_data, grant,
//   sel, ack, busy                 : driven by the arbiter (slave)
interface rr_mux_arbiter_if #(
  parameter int unsigned N = rr_arb_pkg::DEFAULT_N
);
  import rr_arb_pkg::*;

  logic [NREQ-1:0] req;
  logic [N-1:0]    d0;
  logic [N-1:0]    d1;
  logic [N-1:0]    d2;
  logic [N-1:0]    d3;
  logic            out_ready;
  logic            out_valid;
  logic [N-1:0]    out_data;
  logic [NREQ-1:0] grant;
  logic [1:0]      sel;
  logic [NREQ-1:0] ack;
  logic            busy;

  modport master (
    output req, d0, d1, d2, d3, out_ready,
    input  out_valid, out_data, grant, sel, ack, busy
  );

  modport slave (
    input  req, d0, d1, d2, d3, out_ready,
    output out_valid, out_data, grant, sel, ack, busy
  );

endinterface

// File: rtl/Mux4to1.sv
// Plain 4:1 word multiplexer.
//   sel       : 2-bit select
//   d0..d3    : N-bit data inputs
//   y         : selected word
module Mux4to1 #(
  parameter int unsigned N = 16
) (
  input  logic [1:0]   sel,
  input  logic [N-1:0] d0,
  input  logic [N-1:0] d1,
  input  logic [N-1:0] d2,
  input  logic [N-1:0] d3,
  output logic [N-1:0] y
);

  always_comb begin
    y = '0;
    unique case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      2'd3:    y = d3;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for four requesters with a registered data mux.
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of rr_mux_arbiter_if (req, d0..d3, out_ready in;
//           out_valid, out_data, grant, sel, ack, busy out)
// A grant is taken from IDLE, held in BUSY until out_ready, then the FSM
// returns to IDLE for one cycle before the next grant.
module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_mux_arbiter_if.slave bus
);

  state_t          state;
  state_t          state_nxt;
  idx_t            ptr;
  idx_t            sel_q;
  idx_t            win;
  logic [NREQ-1:0] grant_q;
  logic [N-1:0]    data_q;
  logic [N-1:0]    mux_y;
  logic            start;
  logic            done;

  assign win = rr_pick(bus.req, ptr);

  Mux4to1 #(.N(N)) u_mux (
    .sel (win),
    .d0  (bus.d0),
    .d1  (bus.d1),
    .d2  (bus.d2),
    .d3  (bus.d3),
    .y   (mux_y)
  );

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (|bus.req) begin
          start     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (bus.out_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // sel survives completion so it always names the last owner; ptr only
  // moves on completion, so an abandoned (reset) transfer never advances it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr     <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
    end else if (start) begin
      sel_q   <= win;
      grant_q <= onehot(win);
      data_q  <= mux_y;
    end else if (done) begin
      grant_q <= '0;
      ptr     <= sel_q + 2'd1;
    end
  end

  assign bus.out_valid = (state == BUSY);
  assign bus.busy      = (state == BUSY);
  assign bus.out_data  = data_q;
  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.ack       = done ? grant_q : '0;

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter: N, 16, data width of every requester and of the output.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req  input  4  request per requester i (bit i).
REQ-005 d0, d1, d2, d3  input  N each  requester data words.
REQ-006 out_ready  input  1  downstream can accept out_data this cycle.
REQ-007 out_valid  output  1  out_data holds a granted word.
REQ-008 out_data  output  N  registered word of the granted requester.
REQ-009 grant  output  4  one-hot owner of the current transfer, zero when idle.
REQ-010 sel  output  2  binary index of the current/last granted requester.
REQ-011 ack  output  4  one-cycle completion pulse to the granted requester.
REQ-012 busy  output  1  high in state BUSY.

Function
REQ-013 FSM has exactly two states, IDLE and BUSY.
REQ-014 IDLE with req == 0: stay IDLE; out_valid = 0; grant = 0.
REQ-015 IDLE with req != 0: pick the winner by round-robin search from pointer ptr (ptr, ptr+1, ... mod 4); at the clock edge load sel = winner, grant = onehot(winner), out_data = d[winner], out_valid = 1, go BUSY.
REQ-016 Latency: req sampled in cycle t gives out_valid = 1 in cycle t+1.
REQ-017 BUSY: out_data, sel and grant hold stable regardless of req or d* changes.
REQ-018 Handshake completes in a BUSY cycle with out_ready = 1; ack = grant in that cycle (combinational), zero otherwise.
REQ-019 On completion edge: go IDLE, out_valid = 0, grant = 0, ptr = sel + 1 mod 4 (3 wraps to 0); sel keeps its value.
REQ-020 BUSY with out_ready = 0: stay BUSY indefinitely, no ack.
REQ-021 out_ready while IDLE has no effect.
REQ-022 Requester dropping req while granted does not abort; transfer completes with the latched word.
REQ-023 Requesters deassert or update req in the cycle after their ack; a still-high req is a new request.
REQ-024 Throughput: at most one transfer per two cycles (mandatory IDLE cycle between grants).
REQ-025 ptr changes only on completion; a winner is always the first set bit at or after ptr in circular order.
REQ-026 grant is one-hot or zero at all times; ack is nonzero only if out_valid = 1.

Reset
REQ-027 rst_n = 0 at a rising edge: state = IDLE, ptr = 0, sel = 0, grant = 0, out_valid = 0, out_data = 0, busy = 0.
REQ-028 Reset asserted mid-BUSY abandons the transfer with no ack; the first grant after reset starts search from requester 0.

Structure
REQ-029 Shared package rr_arb_pkg holds the state encoding (IDLE = 0, BUSY = 1), the requester count 4 and the default width 16.
REQ-030 The data path is one instance of the existing Mux4to1 (width N) driven by the combinational winner index, feeding the out_data register.
REQ-031 Winner selection is combinational; ptr, sel, grant, out_data and state are registers.

Verification
REQ-032 Reset, then req = 4'b0001, d0 = 16'hAAAA, out_ready = 1 -> next cycle out_valid = 1, out_data = AAAA, grant = 0001, ack = 0001; then ptr = 1.
REQ-033 req = 4'b1111 held, out_ready = 1 -> grant order 0001, 0010, 0100, 1000, 0001, with one idle cycle between each.
REQ-034 Grant to 2 with out_ready = 0 for 5 cycles while d2 changes -> out_valid, out_data and grant stable, ack = 0; ack = 0100 on the cycle out_ready rises.
REQ-035 ptr = 3, req = 4'b0101 -> grant 0001 (wrap), then ptr = 1, next grant 0100.
REQ-036 rst_n = 0 during BUSY -> next cycle out_valid = 0, grant = 0, no ack; with req = 4'b1010 afterwards -> grant 0010.
REQ-037 Granted requester drops req in the BUSY cycle -> transfer still completes with its latched word and ack pulses.
